// File: rtl/back_layer_gen_if.sv
// back_layer_gen_if: tile ROM request/acknowledge port between the layer generator and ROM/SDRAM.
interface back_layer_gen_if #(
    parameter int BPP     = 4,
    parameter int TILE_AW = 8,
    parameter int BANK_W  = 2
);
    logic [BANK_W+TILE_AW+2:0] ROM_ADDR;
    logic                      ROM_REQ;
    logic                      ROM_ACK;
    logic [8*BPP-1:0]          ROM_DATA;
    modport master (output ROM_ADDR, ROM_REQ, input ROM_ACK, ROM_DATA);
    modport slave  (input ROM_ADDR, ROM_REQ, output ROM_ACK, ROM_DATA);
endinterface

// File: rtl/back_layer_gen.sv
// back_layer_gen: scrolling background tile layer (map RAM, scroll regs, per-tile ROM fetch FSM).
// Define BACK_SHADOW_SCROLL_EN to latch scroll writes into the active regs at the VBLANK rise.
module back_layer_gen #(
    parameter int BPP     = 4,
    parameter int TILE_AW = 8,
    parameter int BANK_W  = 2,
    parameter int MAP_WL2 = 6,
    parameter int MAP_HL2 = 6,
    parameter int SCRL_W  = 9
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic                       CEN_PIX,
    input  logic [8:0]                 HCNT,
    input  logic [8:0]                 VCNT,
    input  logic                       VBLANK,
    input  logic                       INV,
    input  logic [MAP_WL2+MAP_HL2-1:0] CPU_ADDR,
    input  logic [7:0]                 CPU_DIN,
    output logic [7:0]                 CPU_DOUT,
    input  logic                       CPU_CS,
    input  logic                       CPU_WE,
    input  logic [3:0]                 SCRL_WE,
    input  logic [BANK_W-1:0]          TILEBANK,
    back_layer_gen_if.master           rom,
    output logic [BPP-1:0]             PIX,
    output logic                       ROM_LATE
);
    localparam int MAW = MAP_WL2 + MAP_HL2;
    typedef enum logic [1:0] {IDLE, MAP, REQ} state_t;
    state_t state, state_nx;
    logic [TILE_AW-1:0] map_ram [2**MAW];
    logic [SCRL_W-1:0]  scrl_x, scrl_y, h, v, sx, sy, sx_nx;
    logic [MAW-1:0]     map_addr;
    logic [2:0]         row, p;
    logic [8*BPP-1:0]   row_buf, buf_d, shifter;
    logic               vb_q, vb_rise, grp_start, grp_end, got, late_set;
    assign h         = SCRL_W'(INV ? ~HCNT : HCNT);
    assign v         = SCRL_W'(INV ? ~VCNT : VCNT);
    assign sx        = h + scrl_x;
    assign sy        = v + scrl_y;
    assign sx_nx     = sx + SCRL_W'(8);
    assign p         = INV ? ~sx[2:0] : sx[2:0];
    assign grp_start = CEN_PIX && sx[2:0] == 3'd0;
    assign grp_end   = CEN_PIX && sx[2:0] == 3'd7;
    assign vb_rise   = VBLANK && !vb_q;
    always_ff @(posedge clk)
        if (RESET) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state == MAP ? REQ :
                   state == REQ ? ((rom.ROM_ACK || grp_end) ? IDLE : REQ) :
                   (grp_start ? MAP : IDLE);
    end
    // An ACK coinciding with the deadline still counts, so the shifter loads from buf_d.
    always_comb begin
        rom.ROM_REQ = state == REQ;
        got         = state == REQ && rom.ROM_ACK;
        late_set    = state == REQ && !rom.ROM_ACK && grp_end;
        buf_d       = got ? rom.ROM_DATA : late_set ? '0 : row_buf;
    end
    always_ff @(posedge clk)
        if (CPU_CS && CPU_WE) map_ram[CPU_ADDR] <= CPU_DIN[TILE_AW-1:0];
    always_ff @(posedge clk) begin
        if (RESET) begin
            CPU_DOUT     <= '0;
            map_addr     <= '0;
            row          <= '0;
            rom.ROM_ADDR <= '0;
            row_buf      <= '0;
            shifter      <= '0;
            PIX          <= '0;
            ROM_LATE     <= 1'b0;
            vb_q         <= 1'b0;
        end else begin
            if (CPU_CS && !CPU_WE) CPU_DOUT <= 8'(map_ram[CPU_ADDR]);
            if (state == IDLE && grp_start) begin
                map_addr <= {sy[MAP_HL2+2:3], sx_nx[MAP_WL2+2:3]};
                row      <= sy[2:0];
            end
            if (state == MAP) rom.ROM_ADDR <= {TILEBANK, map_ram[map_addr], row};
            row_buf <= buf_d;
            if (grp_end) shifter <= buf_d;
            if (CEN_PIX) PIX <= shifter[p*BPP +: BPP];
            ROM_LATE <= late_set || (ROM_LATE && !vb_rise);
            vb_q     <= VBLANK;
        end
    end
`ifdef BACK_SHADOW_SCROLL_EN
    logic [SCRL_W-1:0] shd_x, shd_y;
    always_ff @(posedge clk) begin
        if (RESET) begin
            shd_x  <= '0;
            shd_y  <= '0;
            scrl_x <= '0;
            scrl_y <= '0;
        end else begin
            if (SCRL_WE[0]) shd_x[7:0] <= CPU_DIN;
            if (SCRL_WE[1]) shd_x[SCRL_W-1:8] <= CPU_DIN[SCRL_W-9:0];
            if (SCRL_WE[2]) shd_y[7:0] <= CPU_DIN;
            if (SCRL_WE[3]) shd_y[SCRL_W-1:8] <= CPU_DIN[SCRL_W-9:0];
            if (vb_rise) begin
                scrl_x <= shd_x;
                scrl_y <= shd_y;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (RESET) begin
            scrl_x <= '0;
            scrl_y <= '0;
        end else begin
            if (SCRL_WE[0]) scrl_x[7:0] <= CPU_DIN;
            if (SCRL_WE[1]) scrl_x[SCRL_W-1:8] <= CPU_DIN[SCRL_W-9:0];
            if (SCRL_WE[2]) scrl_y[7:0] <= CPU_DIN;
            if (SCRL_WE[3]) scrl_y[SCRL_W-1:8] <= CPU_DIN[SCRL_W-9:0];
        end
    end
`endif
endmodule

// File: tb/tb_back_layer_gen.sv
// tb_back_layer_gen: directed checks of map RAM, scroll/wrap, flip, deadline, reset and shadow scroll.
module tb_back_layer_gen;
    logic        clk = 1'b0;
    logic        RESET, CEN_PIX, VBLANK, INV, CPU_CS, CPU_WE, ROM_LATE;
    logic [8:0]  HCNT, VCNT;
    logic [11:0] CPU_ADDR;
    logic [7:0]  CPU_DIN, CPU_DOUT;
    logic [3:0]  SCRL_WE, PIX;
    logic [1:0]  TILEBANK;
    logic        ack_en;
    int          ack_dly, req_cnt;
    logic [31:0] rom_word;
    int          checks = 0, failures = 0;

    back_layer_gen_if #(.BPP(4), .TILE_AW(8), .BANK_W(2)) rom_bus ();

    back_layer_gen dut (
        .clk(clk), .RESET(RESET), .CEN_PIX(CEN_PIX), .HCNT(HCNT), .VCNT(VCNT),
        .VBLANK(VBLANK), .INV(INV), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_DOUT(CPU_DOUT), .CPU_CS(CPU_CS), .CPU_WE(CPU_WE), .SCRL_WE(SCRL_WE),
        .TILEBANK(TILEBANK), .rom(rom_bus.master), .PIX(PIX), .ROM_LATE(ROM_LATE)
    );

    always #5 clk = ~clk;

    // ROM model: acknowledges ack_dly clocks after ROM_REQ rises when enabled.
    initial begin
        req_cnt = 0;
        rom_bus.ROM_ACK = 1'b0;
        rom_bus.ROM_DATA = '0;
        forever begin
            @(negedge clk);
            rom_bus.ROM_DATA = rom_word;
            if (rom_bus.ROM_REQ && ack_en) begin
                req_cnt++;
                rom_bus.ROM_ACK = (req_cnt == ack_dly);
            end else begin
                req_cnt = 0;
                rom_bus.ROM_ACK = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [8:0] hc);
        HCNT = hc;
        CEN_PIX = 1'b1;
        @(negedge clk);
        CEN_PIX = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_wr(input logic [11:0] a, input logic [7:0] d);
        CPU_ADDR = a; CPU_DIN = d; CPU_CS = 1'b1; CPU_WE = 1'b1;
        @(negedge clk);
        CPU_CS = 1'b0; CPU_WE = 1'b0;
    endtask

    task automatic cpu_rd(input logic [11:0] a);
        CPU_ADDR = a; CPU_CS = 1'b1; CPU_WE = 1'b0;
        @(negedge clk);
        CPU_CS = 1'b0;
    endtask

    task automatic scrl(input logic [3:0] sel, input logic [7:0] d);
        SCRL_WE = sel; CPU_DIN = d;
        @(negedge clk);
        SCRL_WE = 4'd0;
    endtask

    task automatic vpulse();
        VBLANK = 1'b1;
        @(negedge clk);
        VBLANK = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_x(input logic [8:0] x);
        scrl(4'b0001, x[7:0]);
        scrl(4'b0010, {7'd0, x[8]});
`ifdef BACK_SHADOW_SCROLL_EN
        vpulse();
`endif
    endtask

    initial begin
        RESET = 1'b1; CEN_PIX = 1'b0; VBLANK = 1'b0; INV = 1'b0; CPU_CS = 1'b0; CPU_WE = 1'b0;
        HCNT = '0; VCNT = 9'd3; CPU_ADDR = '0; CPU_DIN = '0; SCRL_WE = '0; TILEBANK = 2'b10;
        ack_en = 1'b1; ack_dly = 2; rom_word = 32'hFEDCBA98;
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        chk("rst_req", 32'(rom_bus.ROM_REQ), 0);
        chk("rst_addr", 32'(rom_bus.ROM_ADDR), 0);
        chk("rst_pix", 32'(PIX), 0);
        chk("rst_late", 32'(ROM_LATE), 0);
        chk("rst_dout", 32'(CPU_DOUT), 0);

        cpu_wr(12'd0, 8'h05);
        cpu_wr(12'd1, 8'h0A);
        cpu_wr(12'd2, 8'h07);
        cpu_wr(12'd3, 8'h33);
        cpu_wr(12'd63, 8'h3C);
        cpu_rd(12'd0);
        chk("cpu_rd0", 32'(CPU_DOUT), 32'h05);
        cpu_rd(12'd1);
        chk("cpu_rd1", 32'(CPU_DOUT), 32'h0A);

        // first tile of the line is fetched 8 pixels ahead
        pix(9'd504);
        chk("fetch_addr0", 32'(rom_bus.ROM_ADDR), 32'h102B);
        chk("fetch_req", 32'(rom_bus.ROM_REQ), 1);
        for (int i = 505; i < 512; i++) pix(9'(i));
        for (int i = 0; i < 8; i++) begin
            pix(9'(i));
            chk("pix_norm", 32'(PIX), 32'(rom_word[i*4 +: 4]));
            if (i == 0) chk("fetch_addr1", 32'(rom_bus.ROM_ADDR), 32'h1053);
        end

        set_x(9'h1FF);
        pix(9'd505);
        chk("wrap_col0", 32'(rom_bus.ROM_ADDR), 32'h102B);
        pix(9'd506);
        pix(9'd507);
        set_x(9'h1F8);
        pix(9'd504);
        chk("wrap_col63", 32'(rom_bus.ROM_ADDR), 32'h11E3);
        pix(9'd505);
        pix(9'd506);

        // flipped: HCNT walks down so h walks up through the tile
        set_x(9'h000);
        INV = 1'b1; VCNT = 9'h1FF; rom_word = 32'h76543210;
        pix(9'd7);
        chk("inv_addr", 32'(rom_bus.ROM_ADDR), 32'h1028);
        for (int i = 1; i < 8; i++) pix(9'(7 - i));
        for (int i = 0; i < 8; i++) begin
            pix(9'(511 - i));
            chk("pix_inv", 32'(PIX), 32'(7 - i));
        end

        INV = 1'b0; VCNT = 9'd3; ack_en = 1'b0;
        for (int i = 504; i < 512; i++) pix(9'(i));
        chk("late_req", 32'(rom_bus.ROM_REQ), 0);
        chk("late_set", 32'(ROM_LATE), 1);
        for (int i = 0; i < 8; i++) begin
            pix(9'(i));
            chk("late_pix", 32'(PIX), 0);
        end
        chk("late_sticky", 32'(ROM_LATE), 1);

        ack_en = 1'b1; rom_word = 32'h11111111;
        for (int i = 8; i < 16; i++) pix(9'(i));
        ack_en = 1'b0;
        pix(9'd16);
        chk("pre_rst_pix", 32'(PIX), 1);
        chk("pre_rst_req", 32'(rom_bus.ROM_REQ), 1);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        chk("mid_rst_req", 32'(rom_bus.ROM_REQ), 0);
        chk("mid_rst_pix", 32'(PIX), 0);
        chk("mid_rst_late", 32'(ROM_LATE), 0);
        chk("mid_rst_addr", 32'(rom_bus.ROM_ADDR), 0);
        chk("mid_rst_dout", 32'(CPU_DOUT), 0);

        for (int i = 504; i < 512; i++) pix(9'(i));
        chk("late_again", 32'(ROM_LATE), 1);
        VBLANK = 1'b1;
        @(negedge clk);
        chk("late_clear", 32'(ROM_LATE), 0);
        VBLANK = 1'b0;
        @(negedge clk);

`ifdef BACK_SHADOW_SCROLL_EN
        ack_en = 1'b1;
        scrl(4'b0001, 8'h10);
        pix(9'd504);
        chk("shadow_hold", 32'(rom_bus.ROM_ADDR), 32'h102B);
        pix(9'd505);
        pix(9'd506);
        vpulse();
        pix(9'd504);
        chk("shadow_apply", 32'(rom_bus.ROM_ADDR), 32'h103B);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
